lsu_bus_if: RTL

- Load/store unit sitting directly downstream of the core datapath's memory-access path.
- Replaces the zero-latency data memory port with a variable-latency request/grant/response bus.
- Takes the effective address, store data and funct3 from the datapath. Stalls the core while an access is in flight.
- Returns byte-lane-aligned, sign/zero-extended load data for the register file write-back mux.

---
 rtl/lsu_bus_if.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_if.sv
// Load/store unit bridging the core memory stage to a req/gnt/rvalid data bus.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_if #(
  parameter int unsigned AddressWidth  = 10,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  input  logic                    req_we_i,
  input  logic [2:0]              funct3_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [31:0]             wr_data_i,
  output logic                    stall_o,
  output logic [31:0]             load_data_o,
  output logic                    load_valid_o,
  output logic                    err_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [AddressWidth-1:0] bus_addr_o,
  output logic [3:0]              bus_be_o,
  output logic [31:0]             bus_wdata_o,
  input  logic                    bus_gnt_i,
  input  logic                    bus_rvalid_i,
  input  logic [31:0]             bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                  state_q;
  logic [AddressWidth-1:0] addr_q;
  logic [2:0]              f3_q;
  logic                    legal;
  logic [3:0]              be_next;
  logic [31:0]             wdata_next;
  logic [15:0]             lane_h;
  logic [7:0]              lane_b;
  logic [31:0]             load_ext;
  logic                    complete;
  logic                    timeout_hit;

  assign bus_addr_o = {addr_q[AddressWidth-1:2], 2'b00};

  always_comb begin
    legal      = 1'b0;
    be_next    = 4'b1111;
    wdata_next = wr_data_i;
    case (funct3_i)
      3'b000:         legal = 1'b1;
      3'b001:         legal = ~addr_i[0];
      3'b010:         legal = (addr_i[1:0] == 2'b00);
      3'b100:         legal = ~req_we_i;
      3'b101:         legal = ~req_we_i & ~addr_i[0];
      default:        legal = 1'b0;
    endcase
    case (funct3_i[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = {4{wr_data_i[7:0]}};
      end
      2'b01: begin
        be_next    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wr_data_i[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wr_data_i;
      end
    endcase
  end

  always_comb begin
    lane_h   = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    lane_b   = addr_q[0] ? lane_h[15:8] : lane_h[7:0];
    load_ext = bus_rdata_i;
    case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'b0, lane_b};
      3'b101:  load_ext = {16'b0, lane_h};
      default: load_ext = bus_rdata_i;
    endcase
  end

  always_comb begin
    case (state_q)
      IDLE:    stall_o = req_valid_i & legal;
      REQ:     stall_o = 1'b1;
      WAIT:    stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  // A response only counts once the request has been granted (same cycle in REQ).
  assign complete = bus_rvalid_i & ((state_q == WAIT) | ((state_q == REQ) & bus_gnt_i));

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] tmo_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (state_q == REQ || state_q == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign timeout_hit = (tmo_cnt == CntW'(TimeoutCycles - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      f3_q         <= '0;
      bus_we_o     <= 1'b0;
      bus_req_o    <= 1'b0;
      bus_be_o     <= '0;
      bus_wdata_o  <= '0;
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      err_o        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (legal) begin
              addr_q      <= addr_i;
              f3_q        <= funct3_i;
              bus_we_o    <= req_we_i;
              bus_be_o    <= be_next;
              bus_wdata_o <= wdata_next;
              bus_req_o   <= 1'b1;
              state_q     <= REQ;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        REQ, WAIT: begin
          // Completion wins over a timeout landing on the same cycle.
          if (complete) begin
            bus_req_o <= 1'b0;
            if (!bus_we_o) begin
              load_data_o  <= load_ext;
              load_valid_o <= 1'b1;
            end
            state_q <= DONE;
          end else if (timeout_hit) begin
            bus_req_o <= 1'b0;
            err_o     <= 1'b1;
            state_q   <= DONE;
          end else if (state_q == REQ && bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state_q   <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
